// File: rtl/en64_pipe.sv
// en64_pipe: two-stage pipelined (72,64) SECDED encoder with valid/ready flow
// control on both sides, a per-word XOR injection hook on {check, data} and a
// count of frames accepted downstream.
//
// S1 holds the raw word (data, tag, injection mask). S2 holds the finished
// frame {tag, check ^ inj[71:64], data ^ inj[63:0]}. The check bits are
// computed combinationally from S1, so the parity tree sits between the two
// register stages.
module en64_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_tag,
  input  logic [71:0] in_inj,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] OUT,
  output logic [15:0] word_cnt
);

  // Check-bit parity tree. Each check bit covers 26 data bits, chosen so the
  // downstream syndrome decoder sees 8'h00 for every uncorrupted frame.
  function automatic logic [7:0] check_bits(input logic [63:0] d);
    logic [7:0] c;
    c[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[3]  ^ d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^
           d[10] ^ d[13] ^ d[14] ^ d[17] ^ d[20] ^ d[23] ^ d[24] ^ d[27] ^
           d[35] ^ d[43] ^ d[46] ^ d[47] ^ d[51] ^ d[52] ^ d[53] ^ d[56] ^
           d[57] ^ d[58];
    c[1] = d[0]  ^ d[1]  ^ d[2]  ^ d[8]  ^ d[9]  ^ d[10] ^ d[11] ^ d[12] ^
           d[13] ^ d[14] ^ d[15] ^ d[18] ^ d[21] ^ d[22] ^ d[25] ^ d[28] ^
           d[31] ^ d[32] ^ d[35] ^ d[43] ^ d[51] ^ d[54] ^ d[55] ^ d[59] ^
           d[60] ^ d[61];
    c[2] = d[3]  ^ d[4]  ^ d[5]  ^ d[8]  ^ d[9]  ^ d[10] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[20] ^ d[21] ^ d[22] ^ d[23] ^ d[26] ^ d[29] ^
           d[30] ^ d[33] ^ d[36] ^ d[39] ^ d[40] ^ d[43] ^ d[51] ^ d[59] ^
           d[62] ^ d[63];
    c[3] = d[3]  ^ d[6]  ^ d[7]  ^ d[11] ^ d[12] ^ d[13] ^ d[16] ^ d[17] ^
           d[18] ^ d[24] ^ d[25] ^ d[26] ^ d[27] ^ d[28] ^ d[29] ^ d[30] ^
           d[31] ^ d[34] ^ d[37] ^ d[38] ^ d[41] ^ d[44] ^ d[47] ^ d[48] ^
           d[51] ^ d[59];
    c[4] = d[3]  ^ d[11] ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[24] ^
           d[25] ^ d[26] ^ d[32] ^ d[33] ^ d[34] ^ d[35] ^ d[36] ^ d[37] ^
           d[38] ^ d[39] ^ d[42] ^ d[45] ^ d[46] ^ d[49] ^ d[52] ^ d[55] ^
           d[56] ^ d[59];
    c[5] = d[0]  ^ d[3]  ^ d[11] ^ d[19] ^ d[22] ^ d[23] ^ d[27] ^ d[28] ^
           d[29] ^ d[32] ^ d[33] ^ d[34] ^ d[40] ^ d[41] ^ d[42] ^ d[43] ^
           d[44] ^ d[45] ^ d[46] ^ d[47] ^ d[50] ^ d[53] ^ d[54] ^ d[57] ^
           d[60] ^ d[63];
    c[6] = d[1]  ^ d[4]  ^ d[7]  ^ d[8]  ^ d[11] ^ d[19] ^ d[27] ^ d[30] ^
           d[31] ^ d[35] ^ d[36] ^ d[37] ^ d[40] ^ d[41] ^ d[42] ^ d[48] ^
           d[49] ^ d[50] ^ d[51] ^ d[52] ^ d[53] ^ d[54] ^ d[55] ^ d[58] ^
           d[61] ^ d[62];
    c[7] = d[2]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[12] ^ d[15] ^ d[16] ^ d[19] ^
           d[27] ^ d[35] ^ d[38] ^ d[39] ^ d[43] ^ d[44] ^ d[45] ^ d[48] ^
           d[49] ^ d[50] ^ d[56] ^ d[57] ^ d[58] ^ d[59] ^ d[60] ^ d[61] ^
           d[62] ^ d[63];
    return c;
  endfunction

  logic        s1_v;
  logic [63:0] s1_data;
  logic [7:0]  s1_tag;
  logic [71:0] s1_inj;

  logic        s2_v;
  logic [79:0] s2_frame;

  logic        in_fire;
  logic        s1_adv;
  logic        out_fire;
  logic [7:0]  s1_chk;

  // S1 moves into S2 whenever S2 is empty or is being drained this edge.
  // The input side may accept whenever S1 is empty or S1 is moving on.
  assign s1_adv   = s1_v & (~s2_v | out_ready);
  assign in_ready = ~s1_v | ~s2_v | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_v & out_ready;

  assign s1_chk    = check_bits(s1_data);
  assign out_valid = s2_v;
  assign OUT       = s2_frame;

  // S1: capture the raw word on an input handshake; go empty when the held
  // word moves to S2 and nothing new arrives.
  // NOTE: stage registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let S2 see S1's new word this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
      s1_inj  <= '0;
    end else if (in_fire) begin
      s1_v    <= 1'b1;
      s1_data <= in_data;
      s1_tag  <= in_tag;
      s1_inj  <= in_inj;
    end else if (s1_adv) begin
      s1_v    <= 1'b0;
    end
  end

  // S2: load the encoded, optionally corrupted frame from S1; otherwise hold
  // while stalled, or go empty once the frame has been taken downstream.
  // NOTE: the frame register is reset along with the valid bit so OUT reads
  // 80'h0 out of reset rather than whatever was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_frame <= '0;
    end else if (s1_adv) begin
      s2_v     <= 1'b1;
      s2_frame <= {s1_tag, s1_chk ^ s1_inj[71:64], s1_data ^ s1_inj[63:0]};
    end else if (out_ready) begin
      s2_v     <= 1'b0;
    end
  end

  // Frames accepted downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (out_fire) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_en64_pipe.sv
// tb_en64_pipe: directed self-checking bench for en64_pipe. Inputs change on
// the falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge that moves the pipeline.
module tb_en64_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_tag;
  logic [71:0] in_inj;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_frame;
  logic [15:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  en64_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_inj    (in_inj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (out_frame),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: data, tag, injection mask and hand-derived check byte
  // of the clean data (before any injection).
  localparam int NV = 18;
  logic [63:0] vd [NV];
  logic [7:0]  vt [NV];
  logic [71:0] vi [NV];
  logic [7:0]  vc [NV];

  function automatic logic [79:0] exp_frame(input int i);
    logic [71:0] m;
    m = vi[i];
    return {vt[i], vc[i] ^ m[71:64], vd[i] ^ m[63:0]};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word through an empty pipe with out_ready high: visible after two
  // rising edges, gone after the third.
  task automatic latency_check();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 64'h0; in_tag = 8'h5A; in_inj = '0;
    #1 chk("lat_in_ready", 80'(in_ready), 80'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_edge1_valid", 80'(out_valid), 80'(0));
    @(negedge clk);
    #1 chk("lat_edge2_valid", 80'(out_valid), 80'(1));
    chk("lat_edge2_out", out_frame, {8'h5A, 8'h00, 64'h0});
    @(negedge clk);
    #1 chk("lat_drained", 80'(out_valid), 80'(0));
  endtask

  // Stream vectors [first, first+n) in order; out_ready either held high or
  // randomly toggled. Checks order, content and hold-while-stalled.
  task automatic run_stream(input int first, input int n, input bit rnd, output int cyc);
    int sent = 0;
    int rcvd = 0;
    bit stalled = 1'b0;
    logic [79:0] held = '0;
    cyc = 0;
    while (rcvd < n && cyc < 300) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < n);
      if (sent < n) begin
        in_data = vd[first + sent];
        in_tag  = vt[first + sent];
        in_inj  = vi[first + sent];
      end
      #1;
      if (stalled) begin
        chk("stall_hold_valid", 80'(out_valid), 80'(1));
        chk("stall_hold_out", out_frame, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("frame_%0d", first + rcvd), out_frame, exp_frame(first + rcvd));
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      held    = out_frame;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("stream_all_received", 80'(rcvd), 80'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc;

    vd[0]  = 64'h0;                 vt[0]  = 8'h5A; vi[0]  = '0; vc[0]  = 8'h00;
    vd[1]  = 64'h1;                 vt[1]  = 8'h01; vi[1]  = '0; vc[1]  = 8'h23;
    vd[2]  = 64'h8;                 vt[2]  = 8'h02; vi[2]  = '0; vc[2]  = 8'h3D;
    vd[3]  = 64'h8000_0000_0000_0000; vt[3] = 8'h03; vi[3] = '0; vc[3]  = 8'hA4;
    vd[4]  = 64'hFFFF_FFFF_FFFF_FFFF; vt[4] = 8'h04; vi[4] = '0; vc[4]  = 8'h00;
    vd[5]  = 64'h100;               vt[5]  = 8'h05; vi[5]  = '0; vc[5]  = 8'h46;
    vd[6]  = 64'h800_0000;          vt[6]  = 8'h06; vi[6]  = '0; vc[6]  = 8'hE9;
    vd[7]  = 64'h800_0000_0000;     vt[7]  = 8'h07; vi[7]  = '0; vc[7]  = 8'hA7;
    vd[8]  = 64'h8_0000_0000_0000;  vt[8]  = 8'h08; vi[8]  = '0; vc[8]  = 8'h4F;
    vd[9]  = 64'h800_0000_0000_0000; vt[9] = 8'h09; vi[9]  = '0; vc[9]  = 8'h9E;
    vd[10] = 64'h8_0000_0000;       vt[10] = 8'h0A; vi[10] = '0; vc[10] = 8'hD3;
    vd[11] = 64'h8_0000;            vt[11] = 8'h0B; vi[11] = '0; vc[11] = 8'hF4;
    vd[12] = 64'h800;               vt[12] = 8'h0C; vi[12] = '0; vc[12] = 8'h7A;
    vd[13] = 64'h9;                 vt[13] = 8'h0D; vi[13] = '0; vc[13] = 8'h1E;
    vd[14] = 64'hFFFF_FFFF_FFFF_FFFE; vt[14] = 8'h0E; vi[14] = '0; vc[14] = 8'h23;
    // Injection cases: check-bit flip, data-bit flip, and a mixed pair.
    vd[15] = 64'h1;  vt[15] = 8'hF0; vi[15] = {8'h01, 64'h0};           vc[15] = 8'h23;
    vd[16] = 64'h0;  vt[16] = 8'hF1; vi[16] = {8'h00, 64'h10};          vc[16] = 8'h00;
    vd[17] = 64'h800_0000_0000; vt[17] = 8'hF2;
    vi[17] = {8'h80, 64'h800_0000_0000};                                vc[17] = 8'hA7;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; in_inj = '0; out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    #1 chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out", out_frame, 80'h0);
    chk("rst_word_cnt", 80'(word_cnt), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", 80'(in_ready), 80'(1));

    // Zero word, two-edge latency.
    latency_check();
    chk("cnt_after_latency", 80'(word_cnt), 80'(1));

    // All directed vectors back to back: one per cycle plus two edges of fill.
    run_stream(0, NV, 1'b0, cyc);
    chk("throughput_cycles", 80'(cyc), 80'(NV + 2));
    chk("cnt_after_stream", 80'(word_cnt), 80'(1 + NV));

    // Eight words under random backpressure.
    run_stream(0, 8, 1'b1, cyc);
    chk("cnt_after_backpressure", 80'(word_cnt), 80'(1 + NV + 8));

    // Full stall: five cycles with out_ready low, then release.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = vd[1]; in_tag = vt[1]; in_inj = vi[1];
    #1 chk("stall_accept1_ready", 80'(in_ready), 80'(1));
    @(negedge clk);
    in_data = vd[2]; in_tag = vt[2]; in_inj = vi[2];
    #1 chk("stall_accept2_ready", 80'(in_ready), 80'(1));
    chk("stall_accept2_valid", 80'(out_valid), 80'(0));
    @(negedge clk);
    in_data = vd[3]; in_tag = vt[3]; in_inj = vi[3];
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_full_ready", 80'(in_ready), 80'(0));
      chk("stall_full_out", out_frame, exp_frame(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 80'(in_ready), 80'(1));
    chk("release_out0", out_frame, exp_frame(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("release_valid1", 80'(out_valid), 80'(1));
    chk("release_out1", out_frame, exp_frame(2));
    @(negedge clk);
    #1 chk("release_valid2", 80'(out_valid), 80'(1));
    chk("release_out2", out_frame, exp_frame(3));
    @(negedge clk);
    #1 chk("release_drained", 80'(out_valid), 80'(0));
    chk("cnt_after_stall", 80'(word_cnt), 80'(1 + NV + 8 + 3));

    // Reset with two words in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = vd[5]; in_tag = vt[5]; in_inj = vi[5];
    @(negedge clk);
    in_data = vd[6]; in_tag = vt[6]; in_inj = vi[6];
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("inflight_valid", 80'(out_valid), 80'(1));
    rst = 1'b1;
    #1 chk("midrst_valid", 80'(out_valid), 80'(0));
    chk("midrst_out", out_frame, 80'h0);
    chk("midrst_cnt", 80'(word_cnt), 80'(0));
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("postrst_no_stale", 80'(out_valid), 80'(0));
    end

    // First word after reset sees full latency.
    latency_check();

    // Counter wrap: bring word_cnt to 16'hFFFF, then one more frame.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 64'h0123_4567_89AB_CDEF; in_tag = 8'h77; in_inj = '0;
    repeat (65534) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("cnt_preload", 80'(word_cnt), 80'(16'hFFFF));
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("cnt_wrap", 80'(word_cnt), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
